key_switch_conditioner: RTL and testbench

- Input conditioning stage directly upstream of the Nios system's key and switch PIO inputs.
- Synchronises and debounces the 4 active-low pushbuttons and the 18 slide switches.
- Drives clean levels into key_0_export / switches_export of the Nios system.
- Adds single-cycle press/release/change strobes for the password-entry logic.

---
 rtl/key_switch_conditioner.sv | 169 ++++++++++++++++
 tb/tb_key_switch_conditioner.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_switch_conditioner.sv
// Synchronises and debounces raw pushbuttons and slide switches, adding press/release/change strobes.
// Optional per-key auto-repeat is compiled in with `define KEY_AUTO_REPEAT_EN.
module key_switch_conditioner #(
  parameter int NUM_KEYS      = 4,
  parameter int NUM_SW        = 18,
  parameter int KEY_DB_CYCLES = 1000000,
  parameter int SW_DB_CYCLES  = 500000,
  parameter int CNT_W         = 20,
  parameter int RPT_DELAY     = 25000000,
  parameter int RPT_PERIOD    = 5000000
) (
  input  logic                ref_clk_clk,
  input  logic                ref_reset_reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [NUM_SW-1:0]   sw_raw,
  output logic [NUM_KEYS-1:0] key_0_export,
  output logic [NUM_SW-1:0]   switches_export,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                sw_change
);

  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_DB_CYCLES - 1);

  // Catch a counter too narrow to reach its terminal count at elaboration time.
  if ((KEY_DB_CYCLES < 1) || (SW_DB_CYCLES < 1) ||
      (KEY_DB_CYCLES - 1 >= 2 ** CNT_W) || (SW_DB_CYCLES - 1 >= 2 ** CNT_W)) begin : g_bad_cnt
    $error("key_switch_conditioner: CNT_W too small for the debounce cycle counts");
  end
  if ((RPT_DELAY < 1) || (RPT_PERIOD < 1)) begin : g_bad_rpt
    $error("key_switch_conditioner: auto-repeat timings must be at least 1");
  end

`ifdef KEY_AUTO_REPEAT_EN
  typedef enum logic [1:0] {RELEASED, PRESSED, REPEATING} key_state_e;

  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);

  logic [RPT_W-1:0] hold_cnt [NUM_KEYS];
`else
  typedef enum logic [1:0] {RELEASED, PRESSED} key_state_e;
`endif

  logic [NUM_KEYS-1:0] key_meta, key_sync, key_stable, key_accept;
  logic [NUM_SW-1:0]   sw_meta, sw_sync, sw_stable, sw_accept;
  logic [CNT_W-1:0]    key_cnt [NUM_KEYS];
  logic [CNT_W-1:0]    sw_cnt  [NUM_SW];
  key_state_e          key_state [NUM_KEYS];

  // A bit is accepted on the edge where it has disagreed with its stable value long enough.
  // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    key_accept = '0;
    sw_accept  = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      key_accept[i] = (key_sync[i] != key_stable[i]) && (key_cnt[i] == KEY_LAST);
    for (int i = 0; i < NUM_SW; i++)
      sw_accept[i] = (sw_sync[i] != sw_stable[i]) && (sw_cnt[i] == SW_LAST);
  end

  // NOTE: the counter arrays are plain flops, not RAM, so each element is reset explicitly.
  always_ff @(posedge ref_clk_clk or posedge ref_reset_reset) begin
    if (ref_reset_reset) begin
      key_meta   <= '1;
      key_sync   <= '1;
      key_stable <= '1;
      for (int i = 0; i < NUM_KEYS; i++) key_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, so the chain really is two flops deep.
      key_meta <= key_raw;
      key_sync <= key_meta;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_accept[i]) begin
          key_stable[i] <= key_sync[i];
          key_cnt[i]    <= '0;
        end else if (key_sync[i] != key_stable[i]) begin
          key_cnt[i] <= key_cnt[i] + CNT_W'(1);
        end else begin
          key_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge ref_clk_clk or posedge ref_reset_reset) begin
    if (ref_reset_reset) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      sw_stable <= '0;
      sw_change <= 1'b0;
      for (int i = 0; i < NUM_SW; i++) sw_cnt[i] <= '0;
    end else begin
      sw_meta   <= sw_raw;
      sw_sync   <= sw_meta;
      sw_change <= |sw_accept;
      for (int i = 0; i < NUM_SW; i++) begin
        if (sw_accept[i]) begin
          sw_stable[i] <= sw_sync[i];
          sw_cnt[i]    <= '0;
        end else if (sw_sync[i] != sw_stable[i]) begin
          sw_cnt[i] <= sw_cnt[i] + CNT_W'(1);
        end else begin
          sw_cnt[i] <= '0;
        end
      end
    end
  end

  // Per-key press FSM; strobes fire on the same edge that updates the stable level.
  always_ff @(posedge ref_clk_clk or posedge ref_reset_reset) begin
    if (ref_reset_reset) begin
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        key_state[i] <= RELEASED;
`ifdef KEY_AUTO_REPEAT_EN
        hold_cnt[i]  <= '0;
`endif
      end
    end else begin
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        unique case (key_state[i])
          RELEASED: begin
            if (key_accept[i] && !key_sync[i]) begin
              key_state[i] <= PRESSED;
              key_press[i] <= 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
              hold_cnt[i]  <= '0;
`endif
            end
          end
`ifdef KEY_AUTO_REPEAT_EN
          PRESSED, REPEATING: begin
            if (key_accept[i] && key_sync[i]) begin
              key_state[i]   <= RELEASED;
              key_release[i] <= 1'b1;
              hold_cnt[i]    <= '0;
            end else if (hold_cnt[i] == ((key_state[i] == PRESSED) ? DELAY_LAST : PERIOD_LAST)) begin
              key_state[i] <= REPEATING;
              key_press[i] <= 1'b1;
              hold_cnt[i]  <= '0;
            end else begin
              hold_cnt[i] <= hold_cnt[i] + RPT_W'(1);
            end
          end
`else
          PRESSED: begin
            if (key_accept[i] && key_sync[i]) begin
              key_state[i]   <= RELEASED;
              key_release[i] <= 1'b1;
            end
          end
`endif
          default: key_state[i] <= RELEASED;
        endcase
      end
    end
  end

  assign key_0_export    = key_stable;
  assign switches_export = sw_stable;

endmodule

// File: tb/tb_key_switch_conditioner.sv
// Self-checking bench for key_switch_conditioner: directed scenarios plus random stimulus
// compared cycle by cycle with a sliding-window reference model of the debounce rules.
module tb_key_switch_conditioner;

  localparam int KDB = 8;
  localparam int SDB = 4;
  localparam int RD  = 20;
  localparam int RP  = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_raw = 4'hF;
  logic [17:0] sw_raw = '0;
  logic [3:0]  key_0_export, key_press, key_release;
  logic [17:0] switches_export;
  logic        sw_change;

  key_switch_conditioner #(
    .NUM_KEYS(4), .NUM_SW(18), .KEY_DB_CYCLES(KDB), .SW_DB_CYCLES(SDB),
    .CNT_W(4), .RPT_DELAY(RD), .RPT_PERIOD(RP)
  ) dut (
    .ref_clk_clk(clk),
    .ref_reset_reset(rst),
    .key_raw(key_raw),
    .sw_raw(sw_raw),
    .key_0_export(key_0_export),
    .switches_export(switches_export),
    .key_press(key_press),
    .key_release(key_release),
    .sw_change(sw_change)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: raw samples since reset, and the expected outputs after the latest edge.
  logic [3:0]  key_hist [$];
  logic [17:0] sw_hist [$];
  logic [3:0]  exp_key, exp_press, exp_release;
  logic [17:0] exp_sw;
  logic        exp_chg;
  int          press_time [4];

  // A level is accepted once the raw samples taken 2..DB+1 edges ago all oppose it.
  function automatic logic key_flips(int b);
    for (int j = 2; j <= KDB + 1; j++) begin
      int   idx = key_hist.size() - 1 - j;
      logic v   = (idx >= 0) ? key_hist[idx][b] : 1'b1;
      if (v == exp_key[b]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic sw_flips(int b);
    for (int j = 2; j <= SDB + 1; j++) begin
      int   idx = sw_hist.size() - 1 - j;
      logic v   = (idx >= 0) ? sw_hist[idx][b] : 1'b0;
      if (v == exp_sw[b]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    key_hist.delete();
    sw_hist.delete();
    exp_key = 4'hF; exp_sw = '0;
    exp_press = '0; exp_release = '0; exp_chg = 1'b0;
    for (int b = 0; b < 4; b++) press_time[b] = 0;
  endtask

  // Drive one cycle of raw inputs, advance the model past the edge, return at the next negedge.
  task automatic step(input logic [3:0] k, input logic [17:0] s);
    logic [3:0]  fk;
    logic [17:0] fs;
    key_raw = k;
    sw_raw  = s;
    @(posedge clk);
    cyc++;
    key_hist.push_back(k);
    sw_hist.push_back(s);
    if (key_hist.size() > 64) void'(key_hist.pop_front());
    if (sw_hist.size() > 64) void'(sw_hist.pop_front());
    for (int b = 0; b < 4; b++) fk[b] = key_flips(b);
    for (int b = 0; b < 18; b++) fs[b] = sw_flips(b);
    exp_press = '0;
    exp_release = '0;
    for (int b = 0; b < 4; b++) begin
      if (fk[b]) begin
        exp_key[b] = ~exp_key[b];
        if (!exp_key[b]) begin
          exp_press[b] = 1'b1;
          press_time[b] = cyc;
        end else begin
          exp_release[b] = 1'b1;
        end
      end
`ifdef KEY_AUTO_REPEAT_EN
      else if (!exp_key[b]) begin
        int held = cyc - press_time[b];
        if (held >= RD && (held - RD) % RP == 0) exp_press[b] = 1'b1;
      end
`endif
    end
    exp_sw  = exp_sw ^ fs;
    exp_chg = |fs;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_raw = 4'hF;
    sw_raw = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (key_0_export !== 4'hF || switches_export !== 18'h0) begin
      errors++;
      $display("FAIL reset_levels: key=%h sw=%h, want key=f sw=0", key_0_export, switches_export);
    end
    checks++;
    if (key_press !== 4'h0 || key_release !== 4'h0 || sw_change !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: press=%h release=%h chg=%b, want all 0", key_press, key_release, sw_change);
    end
    rst = 1'b0;
    for (int n = 0; n < 50; n++) begin
      step(4'hF, 18'h0);
      checks++;
      if (key_0_export !== 4'hF || switches_export !== 18'h0 ||
          key_press !== 4'h0 || key_release !== 4'h0 || sw_change !== 1'b0) begin
        errors++;
        $display("FAIL idle cycle %0d: key=%h sw=%h press=%h rel=%h chg=%b, want f/0/0/0/0",
                 n, key_0_export, switches_export, key_press, key_release, sw_change);
      end
    end
  endtask

  task automatic test_key_press();
    int presses = 0, press_at = -1, level_at = -1, releases = 0, release_at = -1;
    for (int n = 1; n <= 25; n++) begin
      step(4'hE, 18'h0);
      if (key_press[0]) begin presses++; if (press_at < 0) press_at = n; end
      if (key_0_export == 4'hE && level_at < 0) level_at = n;
      if (key_release !== 4'h0) releases++;
      checks++;
      if (key_0_export !== exp_key || key_press !== exp_press) begin
        errors++;
        $display("FAIL press_model step %0d: key=%h press=%h, want key=%h press=%h",
                 n, key_0_export, key_press, exp_key, exp_press);
      end
    end
    checks++;
    if (level_at !== 10) begin
      errors++; $display("FAIL press_latency: level at step %0d, want 10", level_at);
    end
    checks++;
    if (presses !== 1 || press_at !== 10) begin
      errors++; $display("FAIL press_pulse: %0d pulses first at %0d, want 1 at 10", presses, press_at);
    end
    checks++;
    if (releases !== 0) begin
      errors++; $display("FAIL press_no_release: %0d release cycles, want 0", releases);
    end
    releases = 0;
    for (int n = 1; n <= 15; n++) begin
      step(4'hF, 18'h0);
      if (key_release[0]) begin releases++; if (release_at < 0) release_at = n; end
      checks++;
      if (key_release !== exp_release || key_press !== exp_press) begin
        errors++;
        $display("FAIL release_model step %0d: rel=%h press=%h, want rel=%h press=%h",
                 n, key_release, key_press, exp_release, exp_press);
      end
    end
    checks++;
    if (releases !== 1 || release_at !== 10 || key_0_export !== 4'hF) begin
      errors++;
      $display("FAIL release_pulse: %0d pulses at %0d key=%h, want 1 at 10 key=f", releases, release_at, key_0_export);
    end
  endtask

  task automatic test_bounce();
    int bad = 0;
    for (int n = 0; n < 55; n++) begin
      logic b = (n < 40) ? logic'((n / 3) % 2) : 1'b1;
      step({2'b11, b, 1'b1}, 18'h0);
      if (key_0_export[1] !== 1'b1 || key_press[1] !== 1'b0) bad++;
      checks++;
      if (key_0_export !== exp_key || key_press !== exp_press) begin
        errors++;
        $display("FAIL bounce_model step %0d: key=%h press=%h, want key=%h press=%h",
                 n, key_0_export, key_press, exp_key, exp_press);
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL bounce_filtered: %0d cycles with key1 low or pressed, want 0", bad);
    end
  endtask

  task automatic test_switch();
    int pulses = 0, pulse_at = -1, level_at = -1;
    for (int n = 1; n <= 12; n++) begin
      step(4'hF, 18'h00005);
      if (sw_change) begin pulses++; if (pulse_at < 0) pulse_at = n; end
      if (switches_export == 18'h00005 && level_at < 0) level_at = n;
      checks++;
      if (switches_export !== exp_sw || sw_change !== exp_chg) begin
        errors++;
        $display("FAIL switch_model step %0d: sw=%h chg=%b, want sw=%h chg=%b",
                 n, switches_export, sw_change, exp_sw, exp_chg);
      end
    end
    checks++;
    if (level_at !== 6 || pulses !== 1 || pulse_at !== 6) begin
      errors++;
      $display("FAIL switch_timing: level at %0d, %0d pulses first at %0d, want 6/1/6", level_at, pulses, pulse_at);
    end
    for (int n = 1; n <= 10; n++) step(4'hF, 18'h0);
    checks++;
    if (switches_export !== 18'h0) begin
      errors++; $display("FAIL switch_return: sw=%h, want 0", switches_export);
    end
  endtask

  task automatic test_reset_mid();
    int press_at = -1, bad = 0;
    for (int n = 1; n <= 7; n++) step(4'h7, 18'h0);
    rst = 1'b1;
    model_reset();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (key_0_export !== 4'hF || key_press !== 4'h0 || key_release !== 4'h0 || sw_change !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL reset_mid_quiet: %0d cycles with non-reset outputs, want 0", bad);
    end
    rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step(4'h7, 18'h0);
      if (key_press[3] && press_at < 0) press_at = n;
      checks++;
      if (key_0_export !== exp_key || key_press !== exp_press) begin
        errors++;
        $display("FAIL reset_mid_model step %0d: key=%h press=%h, want key=%h press=%h",
                 n, key_0_export, key_press, exp_key, exp_press);
      end
    end
    checks++;
    if (press_at !== 10) begin
      errors++; $display("FAIL reset_mid_press: press at step %0d, want 10", press_at);
    end
    for (int n = 0; n < 15; n++) step(4'hF, 18'h0);
  endtask

  task automatic test_hold();
    int got [$];
    int want [$];
    int releases = 0;
    logic ok;
    want.push_back(10);
`ifdef KEY_AUTO_REPEAT_EN
    for (int t = 10 + RD; t <= 60; t += RP) want.push_back(t);
`endif
    for (int n = 1; n <= 60; n++) begin
      step(4'hB, 18'h0);
      if (key_press[2]) got.push_back(n);
      checks++;
      if (key_press !== exp_press || key_release !== exp_release) begin
        errors++;
        $display("FAIL hold_model step %0d: press=%h rel=%h, want press=%h rel=%h",
                 n, key_press, key_release, exp_press, exp_release);
      end
    end
    ok = (got.size() == want.size());
    if (ok) foreach (want[i]) if (got[i] != want[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold_press_times: %0d pulses (first at %0d), want %0d pulses first at 10",
               got.size(), (got.size() > 0) ? got[0] : -1, want.size());
    end
    for (int n = 1; n <= 20; n++) begin
      step(4'hF, 18'h0);
      if (key_release[2]) releases++;
      checks++;
      if (key_press !== exp_press || key_release !== exp_release) begin
        errors++;
        $display("FAIL hold_release_model step %0d: press=%h rel=%h, want press=%h rel=%h",
                 n, key_press, key_release, exp_press, exp_release);
      end
    end
    checks++;
    if (releases !== 1) begin
      errors++; $display("FAIL hold_release_count: %0d pulses, want 1", releases);
    end
  endtask

  task automatic test_random();
    logic [3:0]  kv = 4'hF;
    logic [17:0] sv = '0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 9) == 0) kv[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) sv[$urandom_range(0, 17)] ^= 1'b1;
      if ($urandom_range(0, 40) == 0) sv ^= 18'h3_0000 >> $urandom_range(0, 16);
      step(kv, sv);
      checks++;
      if (key_0_export !== exp_key || switches_export !== exp_sw) begin
        errors++;
        $display("FAIL rand_levels cyc %0d: key=%h sw=%h, want key=%h sw=%h",
                 cyc, key_0_export, switches_export, exp_key, exp_sw);
      end
      checks++;
      if (key_press !== exp_press || key_release !== exp_release || sw_change !== exp_chg) begin
        errors++;
        $display("FAIL rand_strobes cyc %0d: press=%h rel=%h chg=%b, want press=%h rel=%h chg=%b",
                 cyc, key_press, key_release, sw_change, exp_press, exp_release, exp_chg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_key_press();
    test_bounce();
    test_switch();
    test_reset_mid();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
